// File: rtl/down_timer_if.sv
// down_timer control/status bundle.
// master drives the strobes, slave is the timer.
interface down_timer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_load_val;
  logic             i_load;
  logic             i_start;
  logic             i_stop;
  logic             i_auto_reload;
  logic [WIDTH-1:0] o_count;
  logic             o_busy;
  logic             o_expired;
  logic             o_done;

  modport master (
    output i_load_val,
    output i_load,
    output i_start,
    output i_stop,
    output i_auto_reload,
    input  o_count,
    input  o_busy,
    input  o_expired,
    input  o_done
  );

  modport slave (
    input  i_load_val,
    input  i_load,
    input  i_start,
    input  i_stop,
    input  i_auto_reload,
    output o_count,
    output o_busy,
    output o_expired,
    output o_done
  );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer.
// One-shot or auto-reload, 1-cycle expiry pulse.
module down_timer #(
  parameter int WIDTH = 32
) (
  input logic          i_clk,
  input logic          i_reset,
  down_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload_reg;
  logic             busy;
  logic             expired;
  logic             done;

  logic [WIDTH-1:0] lv;
  logic             ld;
  logic             st;
  logic             sp;
  logic             ar;

  assign lv = bus.i_load_val;
  assign ld = bus.i_load;
  assign st = bus.i_start;
  assign sp = bus.i_stop;
  assign ar = bus.i_auto_reload;

  assign bus.o_count   = count;
  assign bus.o_busy    = busy;
  assign bus.o_expired = expired;
  assign bus.o_done    = done;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      busy       <= 1'b0;
      expired    <= 1'b0;
      done       <= 1'b0;
    end else begin
      expired <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ld) begin
            reload_reg <= lv;
            count      <= lv;
            done       <= 1'b0;
            if (st && lv != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else if (st && count != '0) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (sp) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (ld) begin
              reload_reg <= lv;
            end
            // expiry uses the reload value held before this edge
            if (count == ONE) begin
              expired <= 1'b1;
              if (ar && reload_reg != '0) begin
                count <= reload_reg;
              end else begin
                count <= '0;
                done  <= 1'b1;
                state <= DONE;
                busy  <= 1'b0;
              end
            end else begin
              count <= count - ONE;
            end
          end
        end
        DONE: begin
          if (ld) begin
            reload_reg <= lv;
            count      <= lv;
            done       <= 1'b0;
            state      <= IDLE;
          end else if (st && reload_reg != '0) begin
            count <= reload_reg;
            done  <= 1'b0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
